// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, FSM state
// encoding, operand sign-bit position and an opcode-support helper.
package alu_pkg;

  // ALU opcodes understood by the shared ALU
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  // Operands and results are 9-bit sign-magnitude; bit 8 carries the sign
  localparam int SIGN_BIT = 8;
  localparam int DATA_W   = SIGN_BIT + 1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for opcodes that are allowed to reach the ALU
  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals of the ALU arbiter.
// The master modport is the environment (requesters plus the ALU), the
// slave modport is the arbiter itself.
interface alu_arbiter_if;
  import alu_pkg::*;

  // requester 0
  logic              req0_valid;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;
  // requester 1
  logic              req1_valid;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;
  // responses (payload shared between both requesters)
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_err;
  // shared ALU
  logic [2:0]        alu_instruction;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  // status
  logic              busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_err,
    output resp0_ready, resp1_ready,
    input  alu_instruction, alu_a, alu_b,
    output alu_result,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_err,
    input  resp0_ready, resp1_ready,
    output alu_instruction, alu_a, alu_b,
    input  alu_result,
    output busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way arbiter: request vector in, one-hot grant out.
// With ALU_ARBITER_ROUND_ROBIN_EN defined it alternates between the two
// requesters when both are active (requester 0 wins first after reset);
// otherwise requester 0 always wins and no history is kept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // 1 means requester 1 was served most recently
  logic last_served;

  // Favour the requester that was not served last when both ask
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_served ? 2'b01 : 2'b10;
  end

  // Remember who was served on each accepted transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_served <= 1'b1;
    else if (update) last_served <= grant[1];
  end
`else
  // Requester 0 always has priority; no state needed
  always_comb begin
    grant = {req[1] & ~req[0], req[0]};
  end

  logic unused_inputs;
  assign unused_inputs = ^{clk, reset_n, update};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// ALU arbiter: shares one external ALU between two requesters.
// A request is accepted in IDLE, its opcode is held on the ALU for
// SETTLE_CYCLES cycles (EXEC) and the ALU result is returned to the owning
// requester (RESP). Unsupported opcodes skip the ALU and return an error.
// Build option: define ALU_ARBITER_ROUND_ROBIN_EN for round-robin
// arbitration; the default build gives requester 0 fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,       // 1..4
  parameter logic [2:0] NOP_OP        = OP_NOP
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] CNT_INIT = 2'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              owner;
  logic [1:0]        cnt;
  logic [2:0]        instr;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] result;
  logic              err;
  logic [1:0]        resp_vld;
  logic              owner_ready;

  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  // --- request selection ---------------------------------------------------
  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .update  (accept),
    .grant   (grant)
  );

  // Ready is only offered in IDLE and is forced low while reset is held
  assign bus.req0_ready = reset_n && (state == ST_IDLE) && grant[0];
  assign bus.req1_ready = reset_n && (state == ST_IDLE) && grant[1];
  assign accept         = reset_n && (state == ST_IDLE) && (grant != 2'b00);

  assign sel    = grant[1];
  assign req_op = sel ? bus.req1_op : bus.req0_op;
  assign req_a  = sel ? bus.req1_a  : bus.req0_a;
  assign req_b  = sel ? bus.req1_b  : bus.req0_b;

  assign owner_ready = owner ? bus.resp1_ready : bus.resp0_ready;

  // --- controller ----------------------------------------------------------
  // Single FSM owning every registered output; instr returns to NOP_OP outside
  // EXEC so that consecutive identical opcodes still produce an edge on the ALU
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      cnt      <= 2'd0;
      instr    <= NOP_OP;
      opnd_a   <= '0;
      opnd_b   <= '0;
      result   <= '0;
      err      <= 1'b0;
      resp_vld <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner  <= sel;
            opnd_a <= req_a;
            opnd_b <= req_b;
            if (op_supported(req_op)) begin
              state <= ST_EXEC;
              instr <= req_op;
              cnt   <= CNT_INIT;
            end else begin
              // Rejected opcodes never reach the ALU
              state    <= ST_RESP;
              result   <= '0;
              err      <= 1'b1;
              resp_vld <= {sel, ~sel};
            end
          end
        end

        ST_EXEC: begin
          if (cnt == 2'd0) begin
            // Last settle cycle: capture the ALU output and release the ALU
            state    <= ST_RESP;
            instr    <= NOP_OP;
            result   <= bus.alu_result;
            err      <= 1'b0;
            resp_vld <= {owner, ~owner};
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        ST_RESP: begin
          if (owner_ready) begin
            state    <= ST_IDLE;
            resp_vld <= 2'b00;
            result   <= '0;
            err      <= 1'b0;
            opnd_a   <= '0;
            opnd_b   <= '0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          instr    <= NOP_OP;
          resp_vld <= 2'b00;
        end
      endcase
    end
  end

  // --- outputs ---------------------------------------------------------------
  assign bus.alu_instruction = instr;
  assign bus.alu_a           = opnd_a;
  assign bus.alu_b           = opnd_b;
  assign bus.resp0_valid     = resp_vld[0];
  assign bus.resp1_valid     = resp_vld[1];
  assign bus.resp_result     = result;
  assign bus.resp_err        = err;
  assign bus.busy            = (state != ST_IDLE);

endmodule
